// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pkg
//  Purpose  : Types and constants shared by the snake mover, collision checker
//             and draw logic: direction and game-state encodings, segment
//             geometry, start position and score ceiling.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package snake_pkg;

    localparam int SEG_W   = 10;
    localparam int SEGS    = 20;
    localparam int STORE_W = SEG_W * SEGS;

    localparam logic [SEG_W-1:0] STEP      = 10'd10;
    localparam logic [SEG_W-1:0] START_X   = 10'd320;
    localparam logic [SEG_W-1:0] START_Y   = 10'd240;
    localparam logic [7:0]       MAX_SCORE = 8'(SEGS - 2);

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // Reverse of a direction; NONE has no reverse, so nothing is ever
    // rejected before the first committed move.
    function automatic dir_t opposite_dir(input dir_t d);
        dir_t r;
        case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            RIGHT:   r = LEFT;
            default: r = NONE;
        endcase
        return r;
    endfunction

    // Fixed priority up > down > left > right when several buttons are held.
    function automatic dir_t button_dir(input logic up, input logic down,
                                        input logic left, input logic right);
        dir_t r;
        if (up)         r = UP;
        else if (down)  r = DOWN;
        else if (left)  r = LEFT;
        else if (right) r = RIGHT;
        else            r = NONE;
        return r;
    endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/snake_body_mover_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : move_tick_gen
//  Purpose  : Move-step pacing divider. Counts 0..TICK_DIV-1 while enabled,
//             held at zero while disabled, and flags the last count as a
//             one-cycle tick.
//  Ports    : clk_i  - clock
//             rst_i  - synchronous active-high reset
//             en_i   - count enable; low clears the count
//             tick_o - high for the cycle the count sits at TICK_DIV-1
//  Revision : 1.0  initial release
// ============================================================================
module move_tick_gen #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int                CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == C_LAST);

endmodule : move_tick_gen
`default_nettype wire

// File: rtl/snake_body_mover.sv
`default_nettype none
// ============================================================================
//  Module   : snake_body_mover
//  Purpose  : Writer side of the snake position/body bus. Owns the head
//             position, the 20-slot body history and the score; paces moves
//             with an internal tick, applies button direction, grows on
//             apple, and freezes on GameOver until reset.
//  Ports    : vga_clk            - clock (all logic on rising edge)
//             reset              - synchronous active-high reset
//             btn_up/down/left/right - debounced direction requests (level)
//             grow               - 1-cycle pulse, apple eaten
//             GameOver           - registered collision flag
//             snakex/snakey      - head position
//             storex/storey      - body history, slot k at [10k+9:10k], k=0 head
//             score              - body length count, saturates at MAX_SCORE
//             moved              - 1-cycle pulse with each new head/store value
//  Revision : 1.0  initial release
// ============================================================================
module snake_body_mover
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               grow,
    input  logic               GameOver,
    output logic [SEG_W-1:0]   snakex,
    output logic [SEG_W-1:0]   snakey,
    output logic [STORE_W-1:0] storex,
    output logic [STORE_W-1:0] storey,
    output logic [7:0]         score,
    output logic               moved
);

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d;
    dir_t                pend_q, pend_d;
    logic                grow_pend_q, grow_pend_d;
    logic [7:0]          score_q, score_d;
    logic [STORE_W-1:0]  storex_q, storex_d;
    logic [STORE_W-1:0]  storey_q, storey_d;
    logic                moved_q, moved_d;

    logic                tick;
    dir_t                btn_req;
    logic [SEG_W-1:0]    head_x, head_y;
    logic [SEG_W-1:0]    new_x, new_y;

    move_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (vga_clk),
        .rst_i  (reset),
        .en_i   (state_q == RUN),
        .tick_o (tick)
    );

    assign btn_req = button_dir(btn_up, btn_down, btn_left, btn_right);
    assign head_x  = storex_q[SEG_W-1:0];
    assign head_y  = storey_q[SEG_W-1:0];

    // Next head from the pending direction; 10-bit arithmetic wraps mod 1024
    // on purpose so the checker sees the out-of-field coordinate.
    always_comb begin
        new_x = head_x;
        new_y = head_y;
        case (pend_q)
            UP:      new_y = head_y - STEP;
            DOWN:    new_y = head_y + STEP;
            LEFT:    new_x = head_x - STEP;
            RIGHT:   new_x = head_x + STEP;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        grow_pend_d = grow_pend_q | grow;
        score_d     = score_q;
        storex_d    = storex_q;
        storey_d    = storey_q;
        moved_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_req != NONE) begin
                    pend_d  = btn_req;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Reversal is judged against the last committed move, not
                // the pending one, so the snake never folds onto its neck.
                if ((btn_req != NONE) && (btn_req != opposite_dir(dir_q))) begin
                    pend_d = btn_req;
                end
                if (GameOver) begin
                    state_d = FROZEN;
                end else if (tick) begin
                    dir_d    = pend_q;
                    storex_d = {storex_q[STORE_W-SEG_W-1:0], new_x};
                    storey_d = {storey_q[STORE_W-SEG_W-1:0], new_y};
                    moved_d  = 1'b1;
                    // A grow landing on the step cycle counts for this step.
                    if (grow_pend_q || grow) begin
                        grow_pend_d = 1'b0;
                        if (score_q < MAX_SCORE) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                end
            end
            default: ;  // FROZEN holds everything until reset
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= NONE;
            pend_q      <= NONE;
            grow_pend_q <= 1'b0;
            score_q     <= 8'd0;
            storex_q    <= {SEGS{START_X}};
            storey_q    <= {SEGS{START_Y}};
            moved_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            grow_pend_q <= grow_pend_d;
            score_q     <= score_d;
            storex_q    <= storex_d;
            storey_q    <= storey_d;
            moved_q     <= moved_d;
        end
    end

    // Head is slot 0 of the history, which keeps the two buses coherent.
    assign snakex = storex_q[SEG_W-1:0];
    assign snakey = storey_q[SEG_W-1:0];
    assign storex = storex_q;
    assign storey = storey_q;
    assign score  = score_q;
    assign moved  = moved_q;

endmodule : snake_body_mover
`default_nettype wire

// File: tb/tb_snake_body_mover.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_body_mover
//  Purpose  : Self-checking bench for snake_body_mover with a fast tick.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snake_body_mover;

    localparam int TDIV = 4;

    logic         vga_clk = 1'b0;
    logic         reset = 1'b1;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic         grow = 1'b0;
    logic         GameOver = 1'b0;
    logic [9:0]   snakex, snakey;
    logic [199:0] storex, storey;
    logic [7:0]   score;
    logic         moved;

    int n_vec = 0;
    int n_err = 0;

    snake_body_mover #(.TICK_DIV(TDIV)) dut (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .grow     (grow),
        .GameOver (GameOver),
        .snakex   (snakex),
        .snakey   (snakey),
        .storex   (storex),
        .storey   (storey),
        .score    (score),
        .moved    (moved)
    );

    always #5 vga_clk = ~vga_clk;

    // ---------------- reference model ----------------
    // phase: 0 waiting for first button, 1 running, 2 frozen
    // directions: 0 none, 1 up, 2 down, 3 left, 4 right
    int m_phase, m_run_cycles, m_dir, m_pend, m_score;
    bit m_gp, m_moved;
    int qx[$];
    int qy[$];

    function automatic int opp(input int d);
        case (d)
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [199:0] pack_hist(input bit is_y);
        logic [199:0] v;
        v = '0;
        for (int k = 0; k < 20; k++) v[k*10 +: 10] = is_y ? 10'(qy[k]) : 10'(qx[k]);
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_run_cycles = 0; m_dir = 0; m_pend = 0; m_score = 0;
        m_gp = 0; m_moved = 0;
        qx.delete(); qy.delete();
        for (int k = 0; k < 20; k++) begin qx.push_back(320); qy.push_back(240); end
    endtask

    // Applied once per rising edge using the inputs held across that edge.
    task automatic model_clock();
        int b, old_dir, nx, ny;
        bit step_now;
        if (reset) begin model_reset(); return; end
        b = btn_up ? 1 : btn_down ? 2 : btn_left ? 3 : btn_right ? 4 : 0;
        old_dir = m_dir;
        m_moved = 0;
        if (m_phase == 0) begin
            if (grow) m_gp = 1;
            if (b != 0) begin m_pend = b; m_phase = 1; m_run_cycles = 0; end
        end else if (m_phase == 1) begin
            m_run_cycles++;
            step_now = (m_run_cycles % TDIV) == 0;
            if (GameOver) begin
                m_phase = 2;
                if (grow) m_gp = 1;
            end else if (step_now) begin
                m_dir = m_pend;
                nx = qx[0]; ny = qy[0];
                if (m_pend == 1) ny -= 10;
                if (m_pend == 2) ny += 10;
                if (m_pend == 3) nx -= 10;
                if (m_pend == 4) nx += 10;
                qx.push_front((nx + 1024) % 1024); void'(qx.pop_back());
                qy.push_front((ny + 1024) % 1024); void'(qy.pop_back());
                m_moved = 1;
                if (m_gp || grow) begin
                    if (m_score < 18) m_score++;
                    m_gp = 0;
                end
            end else if (grow) begin
                m_gp = 1;
            end
            if (b != 0 && b != opp(old_dir)) m_pend = b;
        end else begin
            if (grow) m_gp = 1;
        end
    endtask

    task automatic cyc();
        @(posedge vga_clk);
        model_clock();
        #1;
    endtask

    task automatic wait_moved(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            cyc();
            n++;
            if (moved === 1'b1) return;
        end
        n = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit bad;
        logic [199:0] ex, ey;
        reset = 1'b1; repeat (3) cyc(); reset = 1'b0;
        bad = 0;
        repeat (20) begin cyc(); if (moved !== 1'b0) bad = 1; end
        n_vec++; if (bad) begin n_err++; $display("FAIL reset_idle_moved: moved pulsed while idle, required never"); end
        n_vec++; if (snakex !== 10'd320) begin n_err++; $display("FAIL reset_x: got %0d want 320", snakex); end
        n_vec++; if (snakey !== 10'd240) begin n_err++; $display("FAIL reset_y: got %0d want 240", snakey); end
        n_vec++; if (score !== 8'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", score); end
        for (int k = 0; k < 20; k++) begin ex[k*10 +: 10] = 10'd320; ey[k*10 +: 10] = 10'd240; end
        n_vec++; if (storex !== ex || storey !== ey) begin n_err++; $display("FAIL reset_store: got x=%h y=%h want all 320/240", storex, storey); end
    endtask

    task automatic test_move_right();
        int n;
        btn_right = 1'b1; cyc(); btn_right = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wait_moved(12, n);
            n_vec++; if (n != TDIV) begin n_err++; $display("FAIL right_interval%0d: got %0d cycles want %0d", i, n, TDIV); end
            n_vec++; if (snakex !== 10'(320 + 10 * i)) begin n_err++; $display("FAIL right_x%0d: got %0d want %0d", i, snakex, 320 + 10 * i); end
        end
        n_vec++; if (storex[19:0] !== {10'd340, 10'd350} || snakey !== 10'd240) begin
            n_err++; $display("FAIL right_hist: got %0d,%0d y=%0d want 340,350 y=240", storex[19:10], storex[9:0], snakey); end
        cyc();
        n_vec++; if (moved !== 1'b0) begin n_err++; $display("FAIL right_pulse_width: moved got %b want 0", moved); end
        btn_left = 1'b1; cyc(); btn_left = 1'b0;   // reversal, must be ignored
        btn_up = 1'b1; cyc(); btn_up = 1'b0;
        wait_moved(8, n);
        n_vec++; if (n < 0 || snakey !== 10'd230 || snakex !== 10'd350) begin
            n_err++; $display("FAIL reverse_ignored: got x=%0d y=%0d n=%0d want x=350 y=230", snakex, snakey, n); end
    endtask

    task automatic test_growth();
        int n, want;
        grow = 1'b1; repeat (3) cyc(); grow = 1'b0;
        wait_moved(8, n);
        n_vec++; if (n < 0 || score !== 8'd1) begin n_err++; $display("FAIL grow_multi: got %0d want 1", score); end
        for (int i = 0; i < 20; i++) begin
            grow = 1'b1; cyc(); grow = 1'b0;
            wait_moved(8, n);
            want = (i + 2 > 18) ? 18 : i + 2;
            n_vec++; if (n < 0 || score !== 8'(want)) begin n_err++; $display("FAIL grow_sat%0d: got %0d want %0d", i, score, want); end
        end
        n_vec++; if (score !== 8'(m_score) || storey !== pack_hist(1)) begin
            n_err++; $display("FAIL grow_model: score got %0d want %0d", score, m_score); end
    endtask

    task automatic test_wrap_left();
        int n;
        bit hit;
        btn_left = 1'b1; cyc(); btn_left = 1'b0;
        hit = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            cyc();
            if (moved === 1'b1 && snakex === 10'd0) hit = 1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL wrap_reach0: x got %0d want 0", snakex); end
        wait_moved(8, n);
        n_vec++; if (n < 0 || snakex !== 10'd1014 || storex[19:10] !== 10'd0) begin
            n_err++; $display("FAIL wrap_x: got %0d prev %0d want 1014 prev 0", snakex, storex[19:10]); end
    endtask

    task automatic test_gameover();
        logic [199:0] sx, sy;
        logic [7:0] sc;
        bit bad;
        int guard;
        guard = 0;
        while (!(m_phase == 1 && (m_run_cycles + 1) % TDIV == 0) && guard < 10) begin cyc(); guard++; end
        sx = storex; sy = storey; sc = score;
        GameOver = 1'b1; cyc(); GameOver = 1'b0;
        n_vec++; if (moved !== 1'b0 || storex !== sx || storey !== sy) begin
            n_err++; $display("FAIL gameover_step: moved=%b x=%0d want 0 x=%0d", moved, snakex, sx[9:0]); end
        bad = 0;
        for (int c = 0; c < 24; c++) begin
            btn_down = c[0]; btn_right = c[1]; grow = c[2];
            cyc();
            if (moved !== 1'b0 || storex !== sx || storey !== sy || score !== sc) bad = 1;
        end
        btn_down = 1'b0; btn_right = 1'b0; grow = 1'b0;
        n_vec++; if (bad) begin n_err++; $display("FAIL frozen_hold: x=%0d y=%0d score=%0d want %0d %0d %0d", snakex, snakey, score, sx[9:0], sy[9:0], sc); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit bad;
        reset = 1'b1; cyc(); reset = 1'b0;
        btn_right = 1'b1; cyc(); btn_right = 1'b0;
        wait_moved(8, n);
        grow = 1'b1; cyc(); grow = 1'b0;
        reset = 1'b1; cyc(); reset = 1'b0;
        n_vec++; if (snakex !== 10'd320 || snakey !== 10'd240 || score !== 8'd0 || moved !== 1'b0 ||
                     storex !== pack_hist(0) || storey !== pack_hist(1)) begin
            n_err++; $display("FAIL midrun_reset: x=%0d y=%0d score=%0d moved=%b want 320 240 0 0", snakex, snakey, score, moved); end
        bad = 0;
        repeat (10) begin cyc(); if (moved !== 1'b0) bad = 1; end
        n_vec++; if (bad) begin n_err++; $display("FAIL midrun_idle: moved pulsed after reset, required never"); end
        btn_up = 1'b1; cyc(); btn_up = 1'b0;
        wait_moved(8, n);
        n_vec++; if (n < 0 || score !== 8'd0 || snakey !== 10'd230) begin
            n_err++; $display("FAIL midrun_nogrow: score=%0d y=%0d want 0 230", score, snakey); end
    endtask

    task automatic test_random();
        int frozen_for;
        frozen_for = 0;
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
            if ($urandom_range(0, 5) == 0) begin
                btn_up = 1'($urandom); btn_down = 1'($urandom); btn_left = 1'($urandom); btn_right = 1'($urandom);
            end
            grow = ($urandom_range(0, 7) == 0);
            GameOver = ($urandom_range(0, 299) == 0);
            reset = (frozen_for > 30);
            cyc();
            frozen_for = (m_phase == 2) ? frozen_for + 1 : 0;
            n_vec++;
            if (snakex !== 10'(qx[0]) || snakey !== 10'(qy[0]) || score !== 8'(m_score) || moved !== m_moved ||
                storex !== pack_hist(0) || storey !== pack_hist(1)) begin
                n_err++;
                $display("FAIL random_c%0d: x=%0d y=%0d score=%0d moved=%b want x=%0d y=%0d score=%0d moved=%b",
                         c, snakex, snakey, score, moved, qx[0], qy[0], m_score, m_moved);
            end
        end
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; grow = 0; GameOver = 0; reset = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_move_right();
        test_growth();
        test_wrap_left();
        test_gameover();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_snake_body_mover
`default_nettype wire
